// File: rtl/dmem_wait_responder.sv
// Data-memory responder with a req/ready handshake and LATENCY programmable wait states.
// Optional misaligned-access checking (err port) is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_wait_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ready,
    output logic        busy,
    output logic [15:0] test_value
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              mem_wr_c;
    logic              bad_c;
    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef DMEM_MISALIGN_CHK_EN
    logic mis_q, mis_d;
    logic err_q, err_d;
    logic unused_addr;

    assign bad_c       = mis_q;
    assign unused_addr = ^A[31:ADDR_W+2];
`else
    logic unused_addr;

    assign bad_c       = 1'b0;
    assign unused_addr = ^{A[31:ADDR_W+2], A[1:0]};
`endif

    // Next-state, latched request fields and access decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        wd_d     = wd_q;
        rd_d     = rd_q;
        mem_wr_c = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = A[ADDR_W+1:2];
                    we_d    = WE;
                    wd_d    = WD;
`ifdef DMEM_MISALIGN_CHK_EN
                    mis_d   = |A[1:0];
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    state_d = S_RESP;
                    if (we_q) begin
                        mem_wr_c = ~bad_c;
                    end else begin
                        rd_d = bad_c ? '0 : mem_q[idx_q];
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
`ifdef DMEM_MISALIGN_CHK_EN
        err_d   = (state_d == S_RESP) && mis_q;
`endif
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef DMEM_MISALIGN_CHK_EN
            mis_q   <= mis_d;
            err_q   <= err_d;
`endif
        end
    end

    // Reset clears the whole array so an aborted store can never leave a trace
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_wr_c) begin
            mem_q[idx_q] <= wd_q;
        end
    end

    assign RD         = rd_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign test_value = mem_q[0][15:0];
`ifdef DMEM_MISALIGN_CHK_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder (LATENCY = 2, DEPTH = 64); covers
// the misaligned-access path when DMEM_MISALIGN_CHK_EN is defined.
module tb_dmem_wait_responder;

    logic        CLK = 1'b0;
    logic        rst;
    logic        req;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        ready;
    logic        busy;
    logic [15:0] test_value;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        err;
`endif

    int n_vec = 0;
    int n_err = 0;

    dmem_wait_responder #(.DEPTH(64), .ADDR_W(6), .LATENCY(2)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .req        (req),
        .WE         (WE),
        .A          (A),
        .WD         (WD),
        .RD         (RD),
        .ready      (ready),
        .busy       (busy),
        .test_value (test_value)
`ifdef DMEM_MISALIGN_CHK_EN
        ,
        .err        (err)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rq;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic        bsy;
        logic [31:0] rd;
        logic [15:0] tv;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for ready, then drop req for one idle cycle
    task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input string nm, output logic [31:0] rd_o, output logic err_o);
        int  edges;
        bit  got;
        edges = 0;
        got   = 0;
        rd_o  = '0;
        err_o = 1'b0;
        req = 1'b1; WE = we; A = a; WD = wd;
        while (!got && edges < 20) begin
            @(posedge CLK); #1;
            edges++;
            if (ready) begin
                got  = 1;
                rd_o = RD;
`ifdef DMEM_MISALIGN_CHK_EN
                err_o = err;
`endif
            end
        end
        chk({nm, " latency"}, 32'(edges), 32'd3);
        req = 1'b0;
        @(posedge CLK); #1;
    endtask

    logic [31:0] rd_v;
    logic        err_v;

    initial begin
        rst = 1'b1; req = 1'b0; WE = 1'b0; A = '0; WD = '0;
        #12;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset RD", RD, 32'd0);
        chk("reset test_value", 32'(test_value), 32'd0);
`ifdef DMEM_MISALIGN_CHK_EN
        chk("reset err", 32'(err), 32'd0);
`endif
        @(negedge CLK) rst = 1'b0;

        // Reset in the middle of a store aborts it
        @(negedge CLK);
        req = 1'b1; WE = 1'b1; A = 32'h0; WD = 32'h1234ABCD;
        @(posedge CLK); #1;
        chk("abort accept busy", 32'(busy), 32'd1);
        @(posedge CLK); #1;
        rst = 1'b1; req = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(ready), 32'd0);
        @(posedge CLK);
        @(negedge CLK) rst = 1'b0;
        do_txn(1'b0, 32'h0, 32'h0, "abort load", rd_v, err_v);
        chk("abort load RD", rd_v, 32'd0);
        chk("abort test_value", 32'(test_value), 32'd0);

        // Cycle-by-cycle vectors: stores/loads, test_value tap, address wrap
        tbl[0]  = '{1'b1, 1'b1, 32'h8,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        16'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h8,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        16'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h8,   32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        16'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        16'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 1'b1, 32'h0,        16'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 1'b1, 32'h0,        16'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 16'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 16'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h0,   32'h0000CAFE, 1'b0, 1'b1, 32'hDEADBEEF, 16'h0};
        tbl[9]  = '{1'b1, 1'b1, 32'h0,   32'h0000CAFE, 1'b0, 1'b1, 32'hDEADBEEF, 16'h0};
        tbl[10] = '{1'b1, 1'b1, 32'h0,   32'h0000CAFE, 1'b1, 1'b1, 32'hDEADBEEF, 16'hCAFE};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 16'hCAFE};
        tbl[12] = '{1'b1, 1'b1, 32'h0,   32'hFFFF0001, 1'b0, 1'b1, 32'hDEADBEEF, 16'hCAFE};
        tbl[13] = '{1'b1, 1'b1, 32'h0,   32'hFFFF0001, 1'b0, 1'b1, 32'hDEADBEEF, 16'hCAFE};
        tbl[14] = '{1'b1, 1'b1, 32'h0,   32'hFFFF0001, 1'b1, 1'b1, 32'hDEADBEEF, 16'h0001};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 16'h0001};
        tbl[16] = '{1'b1, 1'b1, 32'h104, 32'h55,       1'b0, 1'b1, 32'hDEADBEEF, 16'h0001};
        tbl[17] = '{1'b1, 1'b1, 32'h104, 32'h55,       1'b0, 1'b1, 32'hDEADBEEF, 16'h0001};
        tbl[18] = '{1'b1, 1'b1, 32'h104, 32'h55,       1'b1, 1'b1, 32'hDEADBEEF, 16'h0001};
        tbl[19] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 16'h0001};
        tbl[20] = '{1'b1, 1'b0, 32'h4,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 16'h0001};
        tbl[21] = '{1'b1, 1'b0, 32'h4,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 16'h0001};
        tbl[22] = '{1'b1, 1'b0, 32'h4,   32'h0,        1'b1, 1'b1, 32'h55,       16'h0001};
        tbl[23] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h55,       16'h0001};

        for (int i = 0; i < 24; i++) begin
            req = tbl[i].rq; WE = tbl[i].we; A = tbl[i].a; WD = tbl[i].wd;
            @(posedge CLK); #1;
            chk($sformatf("vec%0d ready", i), 32'(ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("vec%0d RD", i), RD, tbl[i].rd);
            chk($sformatf("vec%0d test_value", i), 32'(test_value), 32'(tbl[i].tv));
        end

        // Inputs changed during WAIT are ignored; req held through ready re-arms
        req = 1'b1; WE = 1'b1; A = 32'h10; WD = 32'h0000AAAA;
        @(posedge CLK); #1;
        chk("latch accept busy", 32'(busy), 32'd1);
        WE = 1'b0; A = 32'h14; WD = 32'h0000BBBB;
        @(posedge CLK); #1;
        chk("latch wait ready", 32'(ready), 32'd0);
        @(posedge CLK); #1;
        chk("latch resp ready", 32'(ready), 32'd1);
        A = 32'h10;
        @(posedge CLK); #1;
        chk("rearm idle busy", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        chk("rearm accept busy", 32'(busy), 32'd1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rearm ready", 32'(ready), 32'd1);
        chk("rearm RD", RD, 32'h0000AAAA);
        req = 1'b0;
        @(posedge CLK); #1;
        do_txn(1'b0, 32'h14, 32'h0, "untouched load", rd_v, err_v);
        chk("untouched RD", rd_v, 32'h0);

`ifdef DMEM_MISALIGN_CHK_EN
        do_txn(1'b1, 32'h6, 32'h77, "mis store", rd_v, err_v);
        chk("mis store err", 32'(err_v), 32'd1);
        chk("mis store err drop", 32'(err), 32'd0);
        do_txn(1'b0, 32'h6, 32'h0, "mis load", rd_v, err_v);
        chk("mis load RD", rd_v, 32'h0);
        chk("mis load err", 32'(err_v), 32'd1);
        do_txn(1'b0, 32'h4, 32'h0, "aligned load", rd_v, err_v);
        chk("aligned load RD", rd_v, 32'h55);
        chk("aligned load err", 32'(err_v), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
Responder end of the processor's data-memory port: a word-addressed data RAM that serves load/store requests over a req/ready handshake, with a programmable number of wait states.
Lets the multi-cycle processor variant stall on slow memory instead of assuming a single-cycle combinational read.
Sits between the core's ALUOut/WriteData/MemWrite outputs and its ReadData input, and keeps the existing test_value debug tap.

Parameters:
DEPTH, 64, number of 32-bit words; must be a power of 2.
ADDR_W, 6, word-index width; equals log2(DEPTH).
LATENCY, 2, wait cycles from request accept to ready; legal range 1..15.

Ports:
CLK  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  1  request valid; sampled only in IDLE.
WE  input  1  1 = store, 0 = load; sampled with req.
A  input  32  byte address; word index = A[ADDR_W+1:2].
WD  input  32  store data; sampled with req.
RD  output  32  load data; valid while ready = 1, held until the next load completes.
ready  output  1  one-cycle completion pulse.
busy  output  1  high from accept through the ready cycle; the core stalls on it.
test_value  output  16  mem[0][15:0], combinational from the array.
err  output  1  exists only with DMEM_MISALIGN_CHK_EN.

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE; ready = 0, busy = 0, RD = 0, err = 0.
  - Wait counter = 0; all DEPTH words cleared to 0, so test_value = 0.
  - Reset mid-transaction aborts it. A pending store is discarded and no ready pulse is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - With req = 1 at the edge: latch A index, WE and WD; load cnt = LATENCY-1; go to WAIT.
  - With req = 0: stay in IDLE.
- WAIT (busy = 1):
  - cnt != 0: decrement cnt.
  - cnt == 0: perform the access at this edge and go to RESP.
  - The access is either mem[idx] <= WD (store) or RD <= mem[idx] (load).
- RESP: ready = 1, busy = 1 for exactly one cycle; next state is always IDLE.
- Latency: with the request accepted at edge E, ready is high in the cycle after edge E+LATENCY.
  - Back-to-back throughput is one access per LATENCY+2 cycles.
- Handshake:
  - The initiator holds req, A, WE and WD stable until ready.
  - The initiator drops req in the cycle after ready unless it is issuing a new request.
  - req seen in IDLE right after RESP is treated as a new request.
  - Changes on req, A, WE or WD during WAIT/RESP are ignored, since inputs were latched at accept.
- Address rules:
  - A[31:ADDR_W+2] are ignored, so out-of-range addresses wrap modulo DEPTH.
  - A[1:0] are ignored unless the optional feature is enabled.
- Store transaction: RD keeps its previous value.
- test_value: reflects a store to word 0 in the RESP cycle of that store.
- Simultaneous events: rst overrides everything; no other concurrent-event cases exist, because only one transaction is ever outstanding.

Optional Feature:
DMEM_MISALIGN_CHK_EN:
- Defined:
  - The err port exists. A request with latched A[1:0] != 0 completes with normal timing.
  - The store is suppressed, RD is forced to 0, and err = 1 together with ready (one cycle only).
  - Aligned accesses give err = 0.
- Undefined: the err port is absent and A[1:0] are silently ignored.

Test Plan:
1. Assert rst mid-WAIT of a store to A = 0x0 with WD = 0x1234ABCD -> busy and ready drop immediately; after release, a load of 0x0 returns RD = 0 and test_value = 0.
2. LATENCY = 2: store A = 0x8, WD = 0xDEADBEEF, then load 0x8 -> each ready arrives 3 cycles after accept; RD = 0xDEADBEEF; busy is high for 3 cycles per transaction.
3. Store A = 0x0, WD = 0x0000CAFE -> test_value = 0xCAFE in the RESP cycle; a later store 0x0 with WD = 0xFFFF0001 gives test_value = 0x0001.
4. DEPTH = 64: store A = 0x104 with WD = 0x55, then load A = 0x4 -> RD = 0x55 (wrap-around).
5. Change A, WE and WD during WAIT -> the access uses the values latched at accept; holding req high through ready starts a second transaction in the following IDLE cycle.
6. With DMEM_MISALIGN_CHK_EN: store A = 0x6 with WD = 0x77 -> err = 1 with ready and word 1 unchanged; a load of 0x6 gives RD = 0 and err = 1; a load of 0x4 gives err = 0.
